// File: rtl/alu_decode_stage_pkg.sv
// Shared decode types: ALU op codes, operand selects, MIPS opcode/funct values
// and the decoded bundle. The optional illegal flag follows ALU_DECODE_ILLEGAL_EN.
package alu_decode_stage_pkg;

   typedef enum logic [4:0] {
      ALU_NONE, ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV, ALU_LUI
   } alu_code_e;

   typedef enum logic [1:0] {A_RS, A_SHAMT, B_RT, B_IMM} operand_sel_e;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   // Immediate kept as the raw 16 bits plus an extend flag so the bundle is width-independent.
   typedef struct packed {
      alu_code_e    control;
      operand_sel_e a_sel;
      operand_sel_e b_sel;
      logic [4:0]   rs;
      logic [4:0]   rt;
      logic [4:0]   dest;
      logic [4:0]   shamt;
      logic [15:0]  imm16;
      logic         imm_sext;
      logic         wb_en;
`ifdef ALU_DECODE_ILLEGAL_EN
      logic         illegal;
`endif
   } decode_bundle_t;

endpackage

// File: rtl/alu_decode_stage_if.sv
// Fetch-to-execute decode interface. master = decode stage, slave = its environment.
// ALU_DECODE_ILLEGAL_EN adds the illegal flag and the saturating illegal counter.
interface alu_decode_stage_if #(parameter int BitWidth = 32);
   import alu_decode_stage_pkg::*;

   // valid/ready: a transfer happens on a rising edge where valid & ready are both 1;
   // a producer holding valid keeps its payload stable until that transfer.
   logic                in_valid;
   logic                in_ready;
   logic [31:0]         instr;
   logic                flush;
   logic                out_valid;
   logic                out_ready;
   alu_code_e           control;
   operand_sel_e        a_sel;
   operand_sel_e        b_sel;
   logic [4:0]          rs;
   logic [4:0]          rt;
   logic [4:0]          dest;
   logic [4:0]          shamt;
   logic [BitWidth-1:0] imm;
   logic                wb_en;
`ifdef ALU_DECODE_ILLEGAL_EN
   logic                illegal;
   logic [15:0]         illegal_count;
`endif

   modport master (
      input  in_valid, instr, flush, out_ready,
      output in_ready, out_valid, control, a_sel, b_sel, rs, rt, dest, shamt, imm, wb_en
`ifdef ALU_DECODE_ILLEGAL_EN
      , output illegal, illegal_count
`endif
   );

   modport slave (
      output in_valid, instr, flush, out_ready,
      input  in_ready, out_valid, control, a_sel, b_sel, rs, rt, dest, shamt, imm, wb_en
`ifdef ALU_DECODE_ILLEGAL_EN
      , input illegal, illegal_count
`endif
   );

endinterface

// File: rtl/alu_decode_stage_table.sv
// Purely combinational MIPS instruction -> decode_bundle_t lookup.
// Unmatched encodings become NOPs (control NONE, no write-back).
module alu_decode_table
   import alu_decode_stage_pkg::*;
(
   input  logic [31:0]    instr,
   output decode_bundle_t bundle
);

   logic [5:0]   op;
   logic [5:0]   funct;
   alu_code_e    control;
   operand_sel_e a_sel;
   operand_sel_e b_sel;
   logic         imm_sext;
   logic         legal;
   logic [4:0]   dest;

   always_comb begin
      op       = instr[31:26];
      funct    = instr[5:0];
      control  = ALU_NONE;
      a_sel    = A_RS;
      b_sel    = B_RT;
      imm_sext = 1'b0;
      legal    = 1'b1;
      case (op)
         OP_SPECIAL: begin
            case (funct)
               F_ADD:  control = ALU_ADD;
               F_ADDU: control = ALU_ADDU;
               F_SUB:  control = ALU_SUB;
               F_SUBU: control = ALU_SUBU;
               F_AND:  control = ALU_AND;
               F_OR:   control = ALU_OR;
               F_XOR:  control = ALU_XOR;
               F_NOR:  control = ALU_NOR;
               F_SLT:  control = ALU_SLT;
               F_SLTU: control = ALU_SLTU;
               F_SLL:  begin control = ALU_SLL; a_sel = A_SHAMT; end
               F_SRL:  begin control = ALU_SRL; a_sel = A_SHAMT; end
               F_SRA:  begin control = ALU_SRA; a_sel = A_SHAMT; end
               F_SLLV: control = ALU_SLLV;
               F_SRLV: control = ALU_SRLV;
               F_SRAV: control = ALU_SRAV;
               default: legal = 1'b0;
            endcase
         end
         OP_ADDI:  begin control = ALU_ADD;  b_sel = B_IMM; imm_sext = 1'b1; end
         OP_ADDIU: begin control = ALU_ADDU; b_sel = B_IMM; imm_sext = 1'b1; end
         OP_SLTI:  begin control = ALU_SLT;  b_sel = B_IMM; imm_sext = 1'b1; end
         OP_SLTIU: begin control = ALU_SLTU; b_sel = B_IMM; imm_sext = 1'b1; end
         OP_ANDI:  begin control = ALU_AND;  b_sel = B_IMM; end
         OP_ORI:   begin control = ALU_OR;   b_sel = B_IMM; end
         OP_XORI:  begin control = ALU_XOR;  b_sel = B_IMM; end
         OP_LUI:   begin control = ALU_LUI;  b_sel = B_IMM; end
         default:  legal = 1'b0;
      endcase
      dest = (op == OP_SPECIAL) ? instr[15:11] : instr[20:16];

      bundle.control  = control;
      bundle.a_sel    = a_sel;
      bundle.b_sel    = b_sel;
      bundle.rs       = instr[25:21];
      bundle.rt       = instr[20:16];
      bundle.dest     = dest;
      bundle.shamt    = instr[10:6];
      bundle.imm16    = instr[15:0];
      bundle.imm_sext = imm_sext;
      bundle.wb_en    = legal && (dest != 5'd0);
`ifdef ALU_DECODE_ILLEGAL_EN
      bundle.illegal  = ~legal;
`endif
   end

endmodule

// File: rtl/alu_decode_stage.sv
// One-entry valid/ready decode stage: decodes fetch instructions and holds the bundle
// for execute. Optional feature macro: ALU_DECODE_ILLEGAL_EN (illegal flag + counter).
module alu_decode_stage
   import alu_decode_stage_pkg::*;
#(
   parameter int BitWidth = 32
) (
   input logic                clk,
   input logic                reset,
   alu_decode_stage_if.master bus
);

   decode_bundle_t dec;
   decode_bundle_t bundle_q;
   logic           valid_q;
   logic           load;

   alu_decode_table u_table (
      .instr  (bus.instr),
      .bundle (dec)
   );

   assign bus.in_ready = ~valid_q | bus.out_ready;
   assign load         = bus.in_valid & bus.in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q           <= 1'b0;
         bundle_q          <= '0;
         bundle_q.control  <= ALU_NONE;
         bundle_q.a_sel    <= A_RS;
         bundle_q.b_sel    <= B_RT;
      end else begin
         // flush wins over a same-cycle load; payload may still update underneath.
         if (bus.flush)          valid_q <= 1'b0;
         else if (load)          valid_q <= 1'b1;
         else if (bus.out_ready) valid_q <= 1'b0;
         if (load) bundle_q <= dec;
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.control   = bundle_q.control;
   assign bus.a_sel     = bundle_q.a_sel;
   assign bus.b_sel     = bundle_q.b_sel;
   assign bus.rs        = bundle_q.rs;
   assign bus.rt        = bundle_q.rt;
   assign bus.dest      = bundle_q.dest;
   assign bus.shamt     = bundle_q.shamt;
   assign bus.wb_en     = bundle_q.wb_en;
   assign bus.imm       = bundle_q.imm_sext
                          ? {{(BitWidth-16){bundle_q.imm16[15]}}, bundle_q.imm16}
                          : {{(BitWidth-16){1'b0}}, bundle_q.imm16};

`ifdef ALU_DECODE_ILLEGAL_EN
   logic [15:0] illegal_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_count_q <= '0;
      end else if (load && !bus.flush && dec.illegal && (illegal_count_q != 16'hFFFF)) begin
         illegal_count_q <= illegal_count_q + 16'd1;
      end
   end

   assign bus.illegal       = bundle_q.illegal;
   assign bus.illegal_count = illegal_count_q;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed + randomized bench for alu_decode_stage with a table-driven reference decoder
// and a depth-1 expected queue tracking the held bundle.
module tb_alu_decode_stage;
  import alu_decode_stage_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_decode_stage_if #(.BitWidth(32)) bus ();

  alu_decode_stage #(.BitWidth(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // reference tables, indexed by funct (R-type) and opcode (I-type)
  alu_code_e r_ctl [64];
  bit        r_ok [64];
  bit        r_shamt [64];
  alu_code_e i_ctl [64];
  bit        i_ok [64];
  bit        i_sext [64];

  typedef struct {
    alu_code_e    control;
    operand_sel_e a_sel;
    operand_sel_e b_sel;
    logic [4:0]   dest;
    logic [31:0]  imm;
    logic         wb_en;
    logic         illegal;
  } ref_t;

  logic [31:0] exp_q[$];
  logic [15:0] exp_cnt;

  task automatic set_r(input int f, input alu_code_e c, input bit sh);
    r_ctl[f] = c; r_ok[f] = 1'b1; r_shamt[f] = sh;
  endtask

  task automatic set_i(input int o, input alu_code_e c, input bit se);
    i_ctl[o] = c; i_ok[o] = 1'b1; i_sext[o] = se;
  endtask

  task automatic init_tables();
    for (int k = 0; k < 64; k++) begin
      r_ctl[k] = ALU_NONE; r_ok[k] = 1'b0; r_shamt[k] = 1'b0;
      i_ctl[k] = ALU_NONE; i_ok[k] = 1'b0; i_sext[k] = 1'b0;
    end
    set_r('h20, ALU_ADD, 0);  set_r('h21, ALU_ADDU, 0); set_r('h22, ALU_SUB, 0);
    set_r('h23, ALU_SUBU, 0); set_r('h24, ALU_AND, 0);  set_r('h25, ALU_OR, 0);
    set_r('h26, ALU_XOR, 0);  set_r('h27, ALU_NOR, 0);  set_r('h2A, ALU_SLT, 0);
    set_r('h2B, ALU_SLTU, 0); set_r('h00, ALU_SLL, 1);  set_r('h02, ALU_SRL, 1);
    set_r('h03, ALU_SRA, 1);  set_r('h04, ALU_SLLV, 0); set_r('h06, ALU_SRLV, 0);
    set_r('h07, ALU_SRAV, 0);
    set_i('h08, ALU_ADD, 1);  set_i('h09, ALU_ADDU, 1); set_i('h0A, ALU_SLT, 1);
    set_i('h0B, ALU_SLTU, 1); set_i('h0C, ALU_AND, 0);  set_i('h0D, ALU_OR, 0);
    set_i('h0E, ALU_XOR, 0);  set_i('h0F, ALU_LUI, 0);
  endtask

  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t r;
    int   op;
    int   fn;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    r.a_sel = A_RS;
    r.b_sel = B_RT;
    r.imm   = 32'h0;
    if (op == 0) begin
      r.illegal = !r_ok[fn];
      r.control = r_ok[fn] ? r_ctl[fn] : ALU_NONE;
      if (r_ok[fn] && r_shamt[fn]) r.a_sel = A_SHAMT;
      r.dest = w[15:11];
    end else begin
      r.illegal = !i_ok[op];
      r.control = i_ok[op] ? i_ctl[op] : ALU_NONE;
      if (i_ok[op]) r.b_sel = B_IMM;
      r.imm  = i_sext[op] ? {{16{w[15]}}, w[15:0]} : {16'h0000, w[15:0]};
      r.dest = w[20:16];
    end
    r.wb_en = !r.illegal && (r.dest != 5'd0);
    return r;
  endfunction

  // scoreboard check
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    ref_t r;
    chk("out_valid", bus.out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      r = ref_decode(exp_q[0]);
      chk("control", bus.control, r.control);
      chk("wb_en", bus.wb_en, r.wb_en);
      chk("rs", bus.rs, exp_q[0][25:21]);
      chk("rt", bus.rt, exp_q[0][20:16]);
      chk("shamt", bus.shamt, exp_q[0][10:6]);
      if (!r.illegal) begin
        chk("a_sel", bus.a_sel, r.a_sel);
        chk("b_sel", bus.b_sel, r.b_sel);
        chk("dest", bus.dest, r.dest);
        if (r.b_sel == B_IMM) chk("imm", bus.imm, r.imm);
      end
`ifdef ALU_DECODE_ILLEGAL_EN
      chk("illegal", bus.illegal, r.illegal);
`endif
    end
`ifdef ALU_DECODE_ILLEGAL_EN
    chk("illegal_count", bus.illegal_count, exp_cnt);
`endif
  endtask

  task automatic check_reset();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_control", bus.control, ALU_NONE);
    chk("rst_a_sel", bus.a_sel, A_RS);
    chk("rst_b_sel", bus.b_sel, B_RT);
    chk("rst_rs", bus.rs, 5'd0);
    chk("rst_rt", bus.rt, 5'd0);
    chk("rst_dest", bus.dest, 5'd0);
    chk("rst_shamt", bus.shamt, 5'd0);
    chk("rst_imm", bus.imm, 32'h0);
    chk("rst_wb_en", bus.wb_en, 1'b0);
`ifdef ALU_DECODE_ILLEGAL_EN
    chk("rst_illegal", bus.illegal, 1'b0);
    chk("rst_illegal_count", bus.illegal_count, 16'h0);
`endif
  endtask

  // driver tasks
  task automatic do_reset(input logic v, input logic [31:0] ins, input logic ordy);
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = v; bus.instr = ins; bus.out_ready = ordy; bus.flush = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_cnt = 16'h0;
    check_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    logic rdy;
    ref_t r;
    @(negedge clk);
    bus.in_valid = v; bus.instr = ins; bus.out_ready = ordy; bus.flush = fl;
    #1;
    rdy = (exp_q.size() == 0) || ordy;
    chk("in_ready", bus.in_ready, rdy);
    @(posedge clk);
    r = ref_decode(ins);
    if (v && rdy && !fl && r.illegal && exp_cnt != 16'hFFFF) exp_cnt++;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
      if (v && rdy) exp_q.push_back(ins);
    end
    #1;
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    int          k;
    logic [31:0] w;
    int          fl [16] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27,
                             'h2A, 'h2B, 'h00, 'h02, 'h03, 'h04, 'h06, 'h07};
    w = $urandom;
    k = $urandom_range(0, 3);
    if (k == 1) begin
      w[31:26] = 6'h00;
      w[5:0]   = 6'(fl[$urandom_range(0, 15)]);
    end else if (k == 2) begin
      w[31:26] = 6'($urandom_range(8, 15));
    end else if (k == 3) begin
      w[31:26] = 6'h00;
    end
    return w;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    exp_cnt = 16'h0;
    init_tables();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.instr = 32'h0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    do_reset(1'b0, 32'h0, 1'b0);

    // directed decodes
    cycle(1'b1, 32'h012A4020, 1'b1, 1'b0);
    chk("add_control", bus.control, ALU_ADD);
    chk("add_rs", bus.rs, 5'd9);
    chk("add_rt", bus.rt, 5'd10);
    chk("add_dest", bus.dest, 5'd8);
    chk("add_wb_en", bus.wb_en, 1'b1);
    cycle(1'b1, 32'h2408FFFF, 1'b1, 1'b0);
    chk("addiu_control", bus.control, ALU_ADDU);
    chk("addiu_imm", bus.imm, 32'hFFFFFFFF);
    chk("addiu_b_sel", bus.b_sel, B_IMM);
    cycle(1'b1, 32'h3508FFFF, 1'b1, 1'b0);
    chk("ori_control", bus.control, ALU_OR);
    chk("ori_imm", bus.imm, 32'h0000FFFF);
    cycle(1'b1, 32'h00094100, 1'b1, 1'b0);
    chk("sll_control", bus.control, ALU_SLL);
    chk("sll_a_sel", bus.a_sel, A_SHAMT);
    chk("sll_shamt", bus.shamt, 5'd4);
    chk("sll_dest", bus.dest, 5'd8);
    cycle(1'b1, 32'h3C05ABCD, 1'b1, 1'b0);
    cycle(1'b1, 32'h00000000, 1'b1, 1'b0);
    chk("nop_control", bus.control, ALU_SLL);
    chk("nop_wb_en", bus.wb_en, 1'b0);
    cycle(1'b1, 32'hFC000000, 1'b1, 1'b0);
    chk("bad_control", bus.control, ALU_NONE);
    chk("bad_wb_en", bus.wb_en, 1'b0);
`ifdef ALU_DECODE_ILLEGAL_EN
    chk("bad_illegal", bus.illegal, 1'b1);
    chk("bad_count", bus.illegal_count, 16'd1);
`endif
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // stall: held bundle stays while a new instruction waits
    cycle(1'b1, 32'h012A4022, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 32'h01095825, 1'b0, 1'b0);
    chk("stall_control", bus.control, ALU_SUB);
    cycle(1'b1, 32'h01095825, 1'b1, 1'b0);
    chk("resume_control", bus.control, ALU_OR);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // flush of incoming and of a held bundle
    cycle(1'b1, 32'h012A4020, 1'b1, 1'b1);
    chk("flush_in_valid", bus.out_valid, 1'b0);
    cycle(1'b1, 32'h012A4020, 1'b0, 1'b0);
    cycle(1'b1, 32'h2408FFFF, 1'b0, 1'b1);
    chk("flush_held_valid", bus.out_valid, 1'b0);

    // reset in the middle of a stall
    cycle(1'b1, 32'h3508FFFF, 1'b0, 1'b0);
    cycle(1'b1, 32'h00094100, 1'b0, 1'b0);
    do_reset(1'b1, 32'h00094100, 1'b0);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_instr(),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
